// File: rtl/multiport_memory_controller.sv
// Boots the RAM from the boot ROM, then round-robin arbitrates the single-ported RAM among NUM_PORTS requesters.
// Latency: a response arrives one cycle after its grant; boot takes 2*BOOT_WORDS cycles after reset.
// Backpressure: requests wait on req_ready (combinational grant); responses are never backpressured.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   boot_done                 high while RUNNING
//   req_valid/ready/write     per-port handshake and direction (ready is one-hot or zero)
//   req_addr/req_wdata        packed per-port address / write data
//   resp_valid/err/data       per-port one-cycle response; data is zero for writes and errors
//   err_count                 saturating count of out-of-range requests
//   memory_error              high in the sticky ERROR state
module multiport_memory_controller #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PORTS   = 2,
  parameter int MEM_WORDS   = 2**ADDR_WIDTH,
  parameter int BOOT_WORDS  = MEM_WORDS,
  parameter bit BYPASS_BOOT = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            boot_done,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            resp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] resp_data,
  output logic [NUM_PORTS-1:0]            resp_err,
  output logic [7:0]                      err_count,
  output logic                            memory_error
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_BOOT_FETCH,
    ST_BOOT_WRITE,
    ST_RUNNING,
    ST_ERROR
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] boot_addr;
  logic [PTR_W-1:0]      rr_ptr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  logic                  gnt_found;
  logic [NUM_PORTS-1:0]  gnt_onehot;
  logic [PTR_W-1:0]      gnt_next_ptr;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic                  gnt_write;
  logic                  gnt_in_range;
  logic                  fire;

  logic                  rd_pend;
  logic [NUM_PORTS-1:0]  rd_sel;

  // Boot image generator standing in for the ROM macro: word i holds i*3.
  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(a) * DATA_WIDTH'(3);
  endfunction

  always_ff @(posedge clk) begin
    rom_data <= rom_word(boot_addr);
  end

  // Single-ported RAM, synchronous read (read-before-write on the same cycle).
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_q <= ram[ram_addr];
  end

  // Round-robin scan: offset i from rr_ptr selects port j, with wrap-around.
  always_comb begin
    gnt_found    = 1'b0;
    gnt_onehot   = '0;
    gnt_next_ptr = rr_ptr;
    gnt_addr     = '0;
    gnt_wdata    = '0;
    gnt_write    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!gnt_found && req_valid[j] &&
            ((int'(rr_ptr) + i == j) || (int'(rr_ptr) + i == j + NUM_PORTS))) begin
          gnt_found     = 1'b1;
          gnt_onehot[j] = 1'b1;
          gnt_addr      = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
          gnt_wdata     = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
          gnt_write     = req_write[j];
          gnt_next_ptr  = (j == NUM_PORTS-1) ? '0 : PTR_W'(j + 1);
        end
      end
    end
  end

  assign gnt_in_range = int'(gnt_addr) < MEM_WORDS;

  always_ff @(posedge clk) begin
    if (rst) state <= BYPASS_BOOT ? ST_RUNNING : ST_BOOT_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    boot_done    = 1'b0;
    memory_error = 1'b0;
    fire         = 1'b0;
    req_ready    = '0;
    ram_we       = 1'b0;
    ram_addr     = boot_addr;
    ram_wdata    = rom_data;
    case (state)
      ST_BOOT_FETCH: state_nxt = ST_BOOT_WRITE;
      ST_BOOT_WRITE: begin
        ram_we    = 1'b1;
        state_nxt = (boot_addr == ADDR_WIDTH'(BOOT_WORDS-1)) ? ST_RUNNING : ST_BOOT_FETCH;
      end
      ST_RUNNING: begin
        boot_done = 1'b1;
        req_ready = gnt_onehot;
        fire      = gnt_found;
        ram_addr  = gnt_addr;
        ram_wdata = gnt_wdata;
        ram_we    = gnt_found && gnt_write && gnt_in_range;
      end
      ST_ERROR: memory_error = 1'b1;
      default: begin
        memory_error = 1'b1;
        state_nxt    = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      boot_addr  <= '0;
      rr_ptr     <= '0;
      resp_valid <= '0;
      resp_err   <= '0;
      rd_pend    <= 1'b0;
      rd_sel     <= '0;
      err_count  <= '0;
    end else begin
      if (state == ST_BOOT_WRITE && boot_addr != ADDR_WIDTH'(BOOT_WORDS-1))
        boot_addr <= boot_addr + 1'b1;
      resp_valid <= fire ? gnt_onehot : '0;
      resp_err   <= (fire && !gnt_in_range) ? gnt_onehot : '0;
      rd_pend    <= fire && !gnt_write && gnt_in_range;
      rd_sel     <= gnt_onehot;
      if (fire) rr_ptr <= gnt_next_ptr;
      if (fire && !gnt_in_range && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  // Read data is steered to the responding port only; everyone else sees zero.
  always_comb begin
    resp_data = '0;
    for (int j = 0; j < NUM_PORTS; j++)
      if (rd_pend && rd_sel[j]) resp_data[j*DATA_WIDTH +: DATA_WIDTH] = ram_q;
  end

endmodule

// File: tb/tb_multiport_memory_controller.sv
module tb_multiport_memory_controller;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NP = 3;
  localparam int MW = 10;
  localparam int BW = 10;

  logic            clk;
  logic            rst;
  logic            boot_done;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_ready;
  logic [NP-1:0]   req_write;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]   resp_valid;
  logic [NP*DW-1:0] resp_data;
  logic [NP-1:0]   resp_err;
  logic [7:0]      err_count;
  logic            memory_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NP-1:0]    vld;
    logic [NP-1:0]    err;
    logic [NP*DW-1:0] dat;
  } exp_t;

  exp_t        sb_q[$];
  logic [DW-1:0] mdl_mem [16];
  int          mdl_err = 0;

  multiport_memory_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP),
    .MEM_WORDS(MW), .BOOT_WORDS(BW), .BYPASS_BOOT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .err_count(err_count), .memory_error(memory_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted request pushes its expected response, which
  // must show up on the following cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [AW-1:0] a;
    logic          pushed;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("resp_valid", resp_valid, e.vld);
        check_eq("resp_err", resp_err, e.err);
        check_eq("resp_data", resp_data, e.dat);
      end else if (resp_valid != '0) begin
        check_eq("resp_spurious", resp_valid, '0);
      end
      pushed = 1'b0;
      for (int k = 0; k < NP; k++) begin
        if (!pushed && req_valid[k] && req_ready[k]) begin
          pushed = 1'b1;
          a = req_addr[k*AW +: AW];
          e.vld = '0;
          e.err = '0;
          e.dat = '0;
          e.vld[k] = 1'b1;
          if (int'(a) >= MW) begin
            e.err[k] = 1'b1;
            if (mdl_err < 255) mdl_err++;
          end else if (req_write[k]) begin
            mdl_mem[a] = req_wdata[k*DW +: DW];
          end else begin
            e.dat[k*DW +: DW] = mdl_mem[a];
          end
          sb_q.push_back(e);
        end
      end
    end
  end

  // One request cycle: inputs applied just after a rising edge, grant checked mid-cycle.
  task automatic drive(input string tag, input logic [NP-1:0] v, input logic [NP-1:0] w,
                       input logic [NP*AW-1:0] a, input logic [NP*DW-1:0] d,
                       input logic [NP-1:0] exp_rdy);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    check_eq(tag, req_ready, exp_rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    drive(tag, '0, '0, '0, '0, '0);
  endtask

  initial begin
    int n;
    logic [AW-1:0] ai;
    for (int i = 0; i < 16; i++) mdl_mem[i] = (i < BW) ? DW'(i * 3) : 'x;

    rst = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    check_eq("rst_boot_done", boot_done, 1'b0);
    check_eq("rst_req_ready", req_ready, '0);
    check_eq("rst_resp_valid", resp_valid, '0);
    check_eq("rst_resp_err", resp_err, '0);
    check_eq("rst_resp_data", resp_data, '0);
    check_eq("rst_err_count", err_count, 8'd0);
    check_eq("rst_memory_error", memory_error, 1'b0);

    // Start booting, then reset again while boot_addr is 6.
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (13) begin
      @(posedge clk);
      #1;
      check_eq("boot_ready_low", req_ready, '0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midboot_boot_done", boot_done, 1'b0);
    rst = 1'b0;

    // Full boot from the restart: 2*BOOT_WORDS cycles.
    n = 0;
    while (!boot_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!boot_done) check_eq("boot_ready_low", req_ready, '0);
    end
    req_valid = '0;
    check_eq("boot_cycles", n, 2 * BW);

    // Read back every booted word on port 0.
    for (int i = 0; i < BW; i++) begin
      ai = AW'(i);
      drive("rd_boot_rdy", 3'b001, 3'b000, {8'd0, ai}, '0, 3'b001);
    end

    // Port 1 writes addr 7, port 0 reads it on the very next cycle.
    drive("wr_p1_rdy", 3'b010, 3'b010, {4'd0, 4'd7, 4'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 3'b010);
    drive("rd_p0_rdy", 3'b001, 3'b000, {4'd0, 4'd0, 4'd7}, '0, 3'b001);

    // Park the pointer at port 0, then all three ports request continuously.
    drive("park_rdy", 3'b100, 3'b000, {4'd0, 4'd0, 4'd0}, '0, 3'b100);
    for (int r = 0; r < 6; r++)
      drive("rr_rdy", 3'b111, 3'b000, {4'd2, 4'd1, 4'd0}, '0, NP'(1 << (r % NP)));

    // Idle: no grants, and no responses once the last one drains.
    idle("idle_rdy");
    repeat (3) begin
      idle("idle_rdy");
      check_eq("idle_resp", resp_valid, '0);
    end

    // Port 1 holds its write while port 0 is granted, then gets its turn.
    drive("hold_p0_rdy", 3'b011, 3'b010, {4'd0, 4'd3, 4'd4}, {32'd0, 32'h00001234, 32'd0}, 3'b001);
    drive("hold_p1_rdy", 3'b010, 3'b010, {4'd0, 4'd3, 4'd4}, {32'd0, 32'h00001234, 32'd0}, 3'b010);

    // Out-of-range read, then enough out-of-range writes to saturate.
    drive("oor_rd_rdy", 3'b100, 3'b000, {4'd12, 4'd0, 4'd0}, '0, 3'b100);
    check_eq("err_count_1", err_count, 8'(mdl_err));
    check_eq("err_count_is_1", err_count, 8'd1);
    for (int r = 0; r < 300; r++)
      drive("oor_wr_rdy", 3'b001, 3'b001, {4'd0, 4'd0, 4'd12}, {64'd0, 32'h00000BAD}, 3'b001);
    idle("idle_rdy");
    check_eq("err_count_sat", err_count, 8'd255);

    // Contents survive the error traffic.
    drive("rd7_rdy", 3'b001, 3'b000, {4'd0, 4'd0, 4'd7}, '0, 3'b001);
    drive("rd3_rdy", 3'b010, 3'b000, {4'd0, 4'd3, 4'd0}, '0, 3'b010);
    drive("rd9_rdy", 3'b100, 3'b000, {4'd9, 4'd0, 4'd0}, '0, 3'b100);
    idle("idle_rdy");
    idle("idle_rdy");
    check_eq("end_boot_done", boot_done, 1'b1);
    check_eq("end_memory_error", memory_error, 1'b0);
    check_eq("end_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multiport_memory_controller.md
Name: multiport_memory_controller

Overview:
Next-generation memory front end: boots RAM from ROM, then arbitrates the single-ported RAM among NUM_PORTS requesters using a round-robin valid/ready handshake. Adds a configurable boot length, per-port responses, and address range checking. Sits between the CPU/GC/IO masters and the ROM/RAM primitives.

Parameters:
ADDR_WIDTH, 8, address width; RAM/ROM depth is 2**ADDR_WIDTH.
DATA_WIDTH, 32, word width.
NUM_PORTS, 2, number of requester ports (>=1).
MEM_WORDS, 2**ADDR_WIDTH, populated words; an address >= MEM_WORDS is out of range.
BOOT_WORDS, MEM_WORDS, words copied from ROM at boot (1..MEM_WORDS).
BYPASS_BOOT, 0, test-bench only: reset enters RUNNING directly.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
boot_done  out  1  high in RUNNING
req_valid  in  NUM_PORTS  per-port request valid
req_ready  out  NUM_PORTS  per-port grant; one-hot or zero
req_write  in  NUM_PORTS  per-port 1 = write, 0 = read
req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data
resp_valid  out  NUM_PORTS  one-cycle response pulse
resp_data  out  NUM_PORTS*DATA_WIDTH  read data; 0 for writes and errors
resp_err  out  NUM_PORTS  qualifies resp_valid: out-of-range access
err_count  out  8  saturating count of out-of-range requests
memory_error  out  1  high in ERROR state

Behaviour:
- Reset values: boot_done=0, req_ready=0, resp_valid=0, resp_err=0, resp_data=0, err_count=0, memory_error=0, rr pointer=0, boot_addr=0, state=BOOT_FETCH (RUNNING if BYPASS_BOOT).
- The ROM and RAM both use a synchronous read with 1-cycle latency.
- BOOT_FETCH: drive ROM/RAM with boot_addr; go to BOOT_WRITE.
- BOOT_WRITE: write rom_data to RAM[boot_addr]. If boot_addr == BOOT_WORDS-1, go to RUNNING; otherwise increment boot_addr and go to BOOT_FETCH. Boot takes 2*BOOT_WORDS cycles after reset deasserts. RAM words at or above BOOT_WORDS are undefined.
- Reset during boot restarts the boot at address 0. All req_ready signals stay 0 outside RUNNING.
- RUNNING arbitration: search ports starting at the rr pointer in increasing order, wrapping. The first port with req_valid high gets req_ready, which is combinational from req_valid and state. A transfer occurs when valid and ready are both high, at most one per cycle. After granting port k, the pointer becomes (k+1) mod NUM_PORTS. With no requests, the pointer holds.
- Accepted in-range write: RAM is written in the same cycle. Next cycle: resp_valid[k]=1, resp_data=0.
- Accepted in-range read: RAM address is presented in the same cycle. Next cycle: resp_valid[k]=1, resp_data[k]=RAM word.
- Out-of-range request (addr >= MEM_WORDS): accepted with no RAM write. Next cycle: resp_valid[k]=1, resp_err[k]=1, resp_data=0. err_count increments and saturates at 255.
- Back-to-back grants give one response per cycle. A write followed by a read to the same address returns the new data.
- Masters must hold req_* stable while valid and not ready. The controller does not apply response backpressure.
- An illegal or unencoded state goes to ERROR. ERROR is sticky until rst, with memory_error=1 and all ready signals 0.
- Widths: boot_addr is ADDR_WIDTH bits. The rr pointer is $clog2(NUM_PORTS) bits, minimum 1.

Test Plan:
- Boot: ADDR_WIDTH=4, BOOT_WORDS=16, ROM[i]=i*3 -> boot_done rises 32 cycles after rst falls; port-0 read of addr 5 returns 15 one cycle after grant.
- Round-robin: NUM_PORTS=3, all valid continuously -> grants in order 0,1,2,0,1,2; each resp_valid arrives one cycle after its grant.
- Write/read: port1 writes 0xDEADBEEF to addr 7, then port0 reads addr 7 on the next cycle -> resp_data[0]=0xDEADBEEF; write response data=0.
- Range check: MEM_WORDS=10, read of addr 12 -> resp_err=1, resp_data=0, err_count=1; RAM contents unchanged. 300 such requests -> err_count=255.
- Reset mid-boot: assert rst at boot_addr=6 -> boot_addr returns to 0, boot_done stays 0, and the full boot completes correctly.
- Idle/hold: req_valid held on port 1 while port 0 is granted -> port 1 waits with its inputs stable and is granted the next cycle; no requests -> req_ready=0 and no resp_valid.
